// File: rtl/smm_tile_accum.sv
// K-deep accumulator for packed 4-lane partial-product tiles, with a registered valid/ready output.
// Define SMM_ACC_SAT_EN for saturating lane adds and a sticky sat_flag; otherwise adds wrap and sat_flag is 0.
module smm_tile_accum #(
    parameter int BLOCKSIZE = 32,
    parameter int DATAWIDTH = BLOCKSIZE*4,
    parameter int ACCWIDTH  = 40,
    parameter int KW        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [KW-1:0]         k_len,
    input  logic [DATAWIDTH-1:0]  C_in,
    input  logic                  in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*ACCWIDTH-1:0] acc_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat_flag
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ACCUM = 1'b1;

    logic                  state_q, state_d;
    logic [KW-1:0]         klat_q, klat_d;
    logic [KW-1:0]         cnt_q, cnt_d;
    logic [ACCWIDTH-1:0]   acc_q [4];
    logic [ACCWIDTH-1:0]   acc_d [4];
    logic [4*ACCWIDTH-1:0] acc_out_q, acc_out_d;
    logic                  out_valid_q, out_valid_d;

    logic [ACCWIDTH-1:0]   ext [4];
    logic [ACCWIDTH-1:0]   sum [4];
    logic [3:0]            lane_en;
    logic [KW-1:0]         k_eff;
    logic [KW-1:0]         k_now;
    logic                  accept;

`ifdef SMM_ACC_SAT_EN
    logic                  sat_q, sat_d;
    logic [ACCWIDTH:0]     wide [4];
    logic [3:0]            lane_ovf;
`endif

    assign in_ready  = !clear && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign acc_out   = acc_out_q;
    assign out_valid = out_valid_q;
    assign k_eff     = (k_len == '0) ? KW'(1) : k_len;
    assign k_now     = (state_q == ST_IDLE) ? k_eff : klat_q;

`ifdef SMM_ACC_SAT_EN
    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

    // Accumulators are always zero in IDLE, so the first-beat load is the same add path.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            ext[i]     = ACCWIDTH'($signed(C_in[i*BLOCKSIZE +: BLOCKSIZE]));
            lane_en[i] = !in_sel || (i % 2 == 1);
`ifdef SMM_ACC_SAT_EN
            wide[i]     = {acc_q[i][ACCWIDTH-1], acc_q[i]} + {ext[i][ACCWIDTH-1], ext[i]};
            lane_ovf[i] = lane_en[i] && (wide[i][ACCWIDTH] != wide[i][ACCWIDTH-1]);
            if (wide[i][ACCWIDTH] != wide[i][ACCWIDTH-1])
                sum[i] = wide[i][ACCWIDTH] ? {1'b1, {(ACCWIDTH-1){1'b0}}}
                                           : {1'b0, {(ACCWIDTH-1){1'b1}}};
            else
                sum[i] = wide[i][ACCWIDTH-1:0];
`else
            sum[i] = acc_q[i] + ext[i];
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        klat_d      = klat_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        out_valid_d = out_valid_q && !out_ready;
`ifdef SMM_ACC_SAT_EN
        sat_d       = sat_q;
`endif
        if (clear) begin
            for (int unsigned i = 0; i < 4; i++) acc_d[i] = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else if (accept) begin
            if (state_q == ST_IDLE) klat_d = k_eff;
            for (int unsigned i = 0; i < 4; i++)
                if (lane_en[i]) acc_d[i] = sum[i];
`ifdef SMM_ACC_SAT_EN
            sat_d = sat_q || (lane_ovf != '0);
`endif
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == k_now) begin
                // Finishing beat overrides any drain of the previous tile in the same edge.
                for (int unsigned i = 0; i < 4; i++) begin
                    acc_out_d[i*ACCWIDTH +: ACCWIDTH] = acc_d[i];
                    acc_d[i] = '0;
                end
                cnt_d       = '0;
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
            end else begin
                state_d = ST_ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            klat_q      <= '0;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < 4; i++) acc_q[i] <= '0;
            acc_out_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef SMM_ACC_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            klat_q      <= klat_d;
            cnt_q       <= cnt_d;
            for (int unsigned i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
            acc_out_q   <= acc_out_d;
            out_valid_q <= out_valid_d;
`ifdef SMM_ACC_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_smm_tile_accum.sv
// Directed bench for smm_tile_accum: tile-level model checked every cycle plus literal expectations.
module tb_smm_tile_accum;

    localparam int BS = 32;
    localparam int AW = 40;

    logic         clk = 1'b0;
    logic         rst, clear, in_sel, in_valid, out_ready;
    logic [7:0]   k_len;
    logic [127:0] C_in;
    logic         in_ready, out_valid, sat_flag;
    logic [159:0] acc_out;
    logic         in_ready32, out_valid32, sat32;
    logic [127:0] acc_out32;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    smm_tile_accum #(.BLOCKSIZE(BS), .DATAWIDTH(4*BS), .ACCWIDTH(AW), .KW(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .k_len(k_len), .C_in(C_in),
        .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
        .sat_flag(sat_flag)
    );

    smm_tile_accum #(.BLOCKSIZE(BS), .DATAWIDTH(4*BS), .ACCWIDTH(32), .KW(8)) dut32 (
        .clk(clk), .rst(rst), .clear(clear), .k_len(k_len), .C_in(C_in),
        .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready32),
        .acc_out(acc_out32), .out_valid(out_valid32), .out_ready(out_ready),
        .sat_flag(sat32)
    );

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [159:0] lanes40(input longint l3, l2, l1, l0);
        logic [159:0] r;
        longint v [4];
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*40 +: 40] = v[i][39:0];
        return r;
    endfunction

    function automatic logic [127:0] lanes32(input longint l3, l2, l1, l0);
        logic [127:0] r;
        longint v [4];
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = v[i][31:0];
        return r;
    endfunction

    // ---------------- behavioural tile model ----------------
    longint       m_sum [4];
    int           m_cnt, m_k;
    bit           m_busy, m_ov, m_sat;
    logic [159:0] m_out;

    function automatic longint lane_add(input longint a, input longint b, inout bit s);
        longint r, mx;
        logic [AW-1:0] t;
        r  = a + b;
        mx = (longint'(1) <<< (AW-1)) - 1;
`ifdef SMM_ACC_SAT_EN
        t = '0;
        if (r > mx) begin r = mx; s = 1'b1; end
        else if (r < -mx-1) begin r = -mx-1; s = 1'b1; end
`else
        t = r[AW-1:0];
        r = longint'($signed(t));
`endif
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_sum[i] = 0;
            m_cnt = 0; m_k = 0; m_busy = 0; m_ov = 0; m_sat = 0; m_out = '0;
        end else begin
            bit acc, fin;
            longint t;
            logic [31:0] lane;
            acc = in_valid && !clear && (!m_ov || out_ready);
            fin = 0;
            if (clear) begin
                for (int i = 0; i < 4; i++) m_sum[i] = 0;
                m_cnt = 0; m_busy = 0;
            end else if (acc) begin
                if (!m_busy) m_k = (k_len == 0) ? 1 : int'(k_len);
                for (int i = 0; i < 4; i++) begin
                    lane = C_in[i*32 +: 32];
                    if (!in_sel || (i % 2 == 1))
                        m_sum[i] = lane_add(m_sum[i], longint'($signed(lane)), m_sat);
                end
                m_cnt++;
                m_busy = 1;
                if (m_cnt == m_k) begin
                    fin = 1;
                    for (int i = 0; i < 4; i++) begin
                        t = m_sum[i];
                        m_out[i*AW +: AW] = t[AW-1:0];
                        m_sum[i] = 0;
                    end
                    m_cnt = 0; m_busy = 0;
                end
            end
            if (fin) m_ov = 1;
            else if (m_ov && out_ready) m_ov = 0;
        end
    end

    always @(negedge clk) begin
        if (rst && chk_en) begin
            chk("in_ready", {159'b0, in_ready}, {159'b0, !clear && (!m_ov || out_ready)});
            chk("out_valid", {159'b0, out_valid}, {159'b0, m_ov});
            chk("acc_out", acc_out, m_out);
            chk("sat_flag", {159'b0, sat_flag}, {159'b0, m_sat});
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int k, input bit sel, input longint l3, l2, l1, l0);
        bit got;
        int n;
        k_len = 8'(k); in_sel = sel; C_in = lanes32(l3, l2, l1, l0); in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk); got = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!got && n < 100);
        in_valid = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
        end
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; in_sel = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; k_len = '0; C_in = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_acc_out", acc_out, '0);
        chk("rst_out_valid", {159'b0, out_valid}, '0);
        chk("rst_sat", {159'b0, sat_flag}, '0);
        @(negedge clk); rst = 1'b1; chk_en = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", {159'b0, in_ready}, 160'd1);
        chk("idle_out_valid", {159'b0, out_valid}, '0);
        chk("idle_acc_out", acc_out, '0);

        // K=2 full mode
        send(2, 0, 1, 2, 3, 4);
        chk("k2_not_yet", {159'b0, out_valid}, '0);
        send(2, 0, 10, -20, 30, -40);
        chk("k2_valid", {159'b0, out_valid}, 160'd1);
        chk("k2_lanes", acc_out, lanes40(11, -18, 33, -36));
        @(posedge clk); #1;
        chk("k2_drop", {159'b0, out_valid}, '0);

        // Half mode
        send(1, 1, 5, 99, 7, 99);
        chk("half_lanes", acc_out, lanes40(5, 0, 7, 0));

        // k_len=0 behaves as a single-beat tile
        send(0, 0, -1, -2, -3, -4);
        chk("k0_lanes", acc_out, lanes40(-1, -2, -3, -4));
        @(posedge clk); #1;

        // Backpressure
        out_ready = 1'b0;
        send(1, 0, 7, 8, 9, 10);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {159'b0, in_ready}, '0);
            chk("bp_hold", acc_out, lanes40(7, 8, 9, 10));
        end
        k_len = 8'd1; in_sel = 1'b0; C_in = lanes32(1, 1, 1, 1); in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_still_held", acc_out, lanes40(7, 8, 9, 10));
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_swap_valid", {159'b0, out_valid}, 160'd1);
        chk("bp_swap_lanes", acc_out, lanes40(1, 1, 1, 1));
        @(posedge clk); #1;
        chk("bp_drain", {159'b0, out_valid}, '0);

        // clear mid-tile
        send(3, 0, 100, 100, 100, 100);
        send(3, 0, 100, 100, 100, 100);
        clear = 1'b1; k_len = 8'd3; C_in = lanes32(50, 50, 50, 50); in_valid = 1'b1;
        #1;
        chk("clr_in_ready", {159'b0, in_ready}, '0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        send(3, 0, 1, 1, 1, 1);
        send(3, 0, 1, 1, 1, 1);
        chk("clr_not_early", {159'b0, out_valid}, '0);
        send(3, 0, 1, 1, 1, 1);
        chk("clr_lanes", acc_out, lanes40(3, 3, 3, 3));

        // k_len changes during accumulation are ignored
        send(3, 0, 1, 2, 3, 4);
        send(9, 0, -5, 5, -5, 5);
        send(1, 0, 100, 0, 0, -1);
        chk("klatch_lanes", acc_out, lanes40(96, 7, -2, 8));

        // Overflow: 40-bit lanes absorb it, 32-bit lanes wrap or saturate
        send(2, 0, 64'h7FFFFFFF, 64'h7FFFFFFF, 64'h7FFFFFFF, 64'h7FFFFFFF);
        send(2, 0, 64'h7FFFFFFF, 64'h7FFFFFFF, 64'h7FFFFFFF, 64'h7FFFFFFF);
        chk("ovf40_lanes", acc_out, lanes40(64'hFFFFFFFE, 64'hFFFFFFFE, 64'hFFFFFFFE, 64'hFFFFFFFE));
        chk("ovf32_valid", {159'b0, out_valid32}, 160'd1);
`ifdef SMM_ACC_SAT_EN
        chk("ovf32_lanes", {32'b0, acc_out32}, {32'b0, {4{32'h7FFFFFFF}}});
        chk("ovf32_sat", {159'b0, sat32}, 160'd1);
`else
        chk("ovf32_lanes", {32'b0, acc_out32}, {32'b0, {4{32'hFFFFFFFE}}});
        chk("ovf32_sat", {159'b0, sat32}, '0);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/smm_tile_accum.md
Name: smm_tile_accum

Overview:
- Downstream consumer of the 2x2 Strassen block multiplier.
- Accepts one packed 4-lane partial-product tile per beat and accumulates K partial tiles per output tile in wider signed lanes, implementing the k-dimension reduction of a blocked matrix product.
- Presents the finished tile through a registered valid/ready output so the next stage (writeback or spike/threshold logic) can stall without losing data.

Parameters:
- BLOCKSIZE, 32: width of one signed input lane.
- DATAWIDTH, BLOCKSIZE*4: width of the packed input tile.
- ACCWIDTH, 40: width of one signed accumulator lane; must be >= BLOCKSIZE.
- KW, 8: width of the k_len port.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous abort of the in-progress accumulation.
- k_len  input  KW  number of partial tiles per output tile; sampled on the first beat of a tile.
- C_in  input  DATAWIDTH  packed signed partial tile; lane i = C_in[i*BLOCKSIZE +: BLOCKSIZE]; lane 3 = MSB.
- in_sel  input  1  half-mode flag for this beat; matches the multiplier's sel.
- in_valid  input  1  C_in/in_sel are valid this cycle.
- in_ready  output  1  block can accept a beat this cycle.
- acc_out  output  4*ACCWIDTH  finished tile; lane i = acc_out[i*ACCWIDTH +: ACCWIDTH].
- out_valid  output  1  acc_out holds a finished tile.
- out_ready  input  1  consumer accepts acc_out.
- sat_flag  output  1  sticky saturation indicator (see Optional Feature).

Behaviour:
- Reset (rst low, async):
  - Outputs: acc_out=0, out_valid=0, sat_flag=0.
  - Internal state: accumulators=0, beat count=0, latched k=0, state=IDLE.
  - Reset asserted mid-tile discards everything.
- Accept rule: a beat is accepted when in_valid && in_ready.
  - in_ready = !clear && (!out_valid || out_ready), combinational.
- Input lane extension: each accepted lane is sign-extended from BLOCKSIZE to ACCWIDTH.
- Half mode: if in_sel=1, only lanes 3 and 1 are added; lanes 2 and 0 keep their value (their input is don't-care).
- States:
  - IDLE: accumulators hold 0.
    - First accepted beat: latch klat = (k_len==0 ? 1 : k_len).
    - Accumulators are loaded with the extended input; there is no add to stale data.
    - Count becomes 1.
    - If klat==1, finish immediately; otherwise go to ACCUM.
  - ACCUM:
    - Each accepted beat adds the extended lanes to the accumulators (2's-complement, ACCWIDTH wrap) and increments the count.
    - When the count reaches klat on an accepted beat, finish.
    - k_len changes during ACCUM are ignored.
  - Finish:
    - In the same edge, the final sum (including the last beat) is written to acc_out and out_valid is set.
    - Accumulators and count are zeroed; state returns to IDLE.
- Output handshake:
  - out_valid drops on an edge with out_valid && out_ready, unless a finish occurs in that same edge. In that case acc_out reloads and out_valid stays 1.
  - acc_out is stable while out_valid && !out_ready.
- Latency: one clock from the final accepted beat to out_valid.
- Back-to-back throughput: one beat per cycle while out_ready=1.
- clear:
  - Zeroes accumulators and count; state returns to IDLE.
  - Does not touch acc_out, out_valid or sat_flag.
  - Forces in_ready=0, so a beat arriving in the same cycle is not accepted. The upstream must hold it.

Optional Feature:
- Macro: SMM_ACC_SAT_EN.
- When defined:
  - Each lane add saturates to [-2^(ACCWIDTH-1), 2^(ACCWIDTH-1)-1].
  - Any saturation sets sat_flag, which is sticky until rst.
- When undefined:
  - Adds wrap modulo 2^ACCWIDTH.
  - sat_flag is tied to 0.

Test Plan:
- Reset then idle: rst low for 3 cycles, then high → acc_out=0, out_valid=0, in_ready=1, sat_flag=0.
- K=2 full mode: k_len=2, out_ready=1.
  - Beat 1: lanes {3,2,1,0} = {1,2,3,4}.
  - Beat 2: lanes = {10,-20,30,-40}.
  - Required: one cycle after beat 2, out_valid=1 with lanes {11,-18,33,-36}, then drops the next cycle.
- Half mode: k_len=1, in_sel=1, lanes {5,99,7,99} → acc_out lanes {5,0,7,0}.
- Backpressure: complete a k_len=1 tile with out_ready=0.
  - Required: in_ready=0 and acc_out held constant for 5 cycles.
  - Raising out_ready allows the next beat to complete, and acc_out updates in the same edge that the old tile drains.
- clear mid-tile: k_len=3, accept 2 beats of all-lanes 100, pulse clear, then 3 beats of all-lanes 1.
  - Required: the result is all-lanes 3.
  - The beat presented during the clear cycle is not accepted.
- Overflow: k_len=2, all lanes 0x7FFFFFFF twice with ACCWIDTH=32.
  - With SMM_ACC_SAT_EN defined: lanes=0x7FFFFFFF and sat_flag=1.
  - Without it: lanes=0xFFFFFFFE and sat_flag=0.
